sevenseg_capture: RTL

Receive-side counterpart of the egg timer's quad seven-segment display driver. Samples the multiplexed `anodes`/`cathodes` bus, waits for each digit's pattern to settle, and decodes the segment pattern back to BCD. Rebuilds the four displayed digits (seconds, tens of seconds, minutes, tens of minutes) and flags malformed scans. Used as a synthesizable self-check on the board and as the display monitor in system benches.

---
 rtl/sevenseg_capture.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/sevenseg_capture.sv
// sevenseg_capture
//
// Monitors a multiplexed quad seven-segment bus (active-low anodes and
// cathodes), waits for each digit's pattern to settle, decodes the segments
// back to BCD and rebuilds the four displayed digits. Malformed scans raise
// sticky error flags.
//
// Optional feature macro: SEVENSEG_CAPTURE_BLANK_EN
//   defined   - all-off cathodes on a legal anode decode as a valid 4'hF
//   undefined - all-off cathodes on a legal anode are a decode error
//
// Parameters:
//   SETTLE       consecutive identical samples needed before capture (1..15)
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   sample_en    one-cycle sample strobe; the bus is only looked at when high
//   anodes       active-low digit selects, bits 3..0 = digits 3..0
//   cathodes     active-low segments {g,f,e,d,c,b,a}
//   clear_err    synchronous clear of the sticky error flags
//   digit0..3    captured BCD value per digit
//   digit_valid  bit N set when digitN holds a successfully decoded value
//   frame_done   one-cycle pulse on completion of an in-order 0,1,2,3 pass
//   decode_err   sticky: unrecognised segment pattern captured
//   anode_err    sticky: illegal anode pattern sampled
//   seq_err      sticky: digit captured out of scan order

module sevenseg_capture #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sample_en,
    input  logic [7:0] anodes,
    input  logic [6:0] cathodes,
    input  logic       clear_err,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit_valid,
    output logic       frame_done,
    output logic       decode_err,
    output logic       anode_err,
    output logic       seq_err
);

    localparam logic [3:0] SettleCnt = 4'(SETTLE);

    typedef enum logic [1:0] {
        StSync    = 2'd0,
        StExpect1 = 2'd1,
        StExpect2 = 2'd2,
        StExpect3 = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [14:0]      prev_q, prev_d;
    logic [3:0][3:0]  digits_q, digits_d;
    logic [3:0]       valid_q, valid_d;
    logic             frame_q, frame_d;
    logic             dec_err_q, dec_err_d;
    logic             an_err_q, an_err_d;
    logic             seq_err_q, seq_err_d;

    logic       legal, blank, same, capture, mis;
    logic [1:0] idx;
    logic       dec_ok;
    logic [3:0] dec_code;
    logic       new_dec, new_an, new_seq;

    // Anode classification and digit index.
    always_comb begin
        legal = 1'b0;
        idx   = 2'd0;
        blank = (anodes == 8'hFF);
        if (anodes[7:4] == 4'hF) begin
            case (anodes[3:0])
                4'b1110: begin legal = 1'b1; idx = 2'd0; end
                4'b1101: begin legal = 1'b1; idx = 2'd1; end
                4'b1011: begin legal = 1'b1; idx = 2'd2; end
                4'b0111: begin legal = 1'b1; idx = 2'd3; end
                default: legal = 1'b0;
            endcase
        end
    end

    // Segment decode.
    always_comb begin
        dec_ok   = 1'b1;
        dec_code = 4'd0;
        case (cathodes)
            7'b1000000: dec_code = 4'd0;
            7'b1111001: dec_code = 4'd1;
            7'b0100100: dec_code = 4'd2;
            7'b0110000: dec_code = 4'd3;
            7'b0011001: dec_code = 4'd4;
            7'b0010010: dec_code = 4'd5;
            7'b0000010: dec_code = 4'd6;
            7'b1111000: dec_code = 4'd7;
            7'b0000000: dec_code = 4'd8;
            7'b0010000: dec_code = 4'd9;
`ifdef SEVENSEG_CAPTURE_BLANK_EN
            7'b1111111: dec_code = 4'hF;
`endif
            default:    dec_ok   = 1'b0;
        endcase
    end

    // Settle counter and capture strobe.
    always_comb begin
        same    = ({anodes, cathodes} == prev_q);
        cnt_d   = cnt_q;
        prev_d  = prev_q;
        capture = 1'b0;
        new_an  = 1'b0;
        if (sample_en) begin
            prev_d = {anodes, cathodes};
            if (legal) begin
                if (same) begin
                    cnt_d = (cnt_q == 4'd15) ? cnt_q : cnt_q + 4'd1;
                end else begin
                    cnt_d = 4'd1;
                end
                // A saturated counter sitting at 15 must not re-capture.
                capture = (cnt_d == SettleCnt) && !(same && cnt_q == 4'd15);
            end else begin
                cnt_d  = 4'd0;
                new_an = !blank;
            end
        end
    end

    // Digit registers and scan-order FSM.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        valid_d  = valid_q;
        frame_d  = 1'b0;
        new_dec  = 1'b0;
        new_seq  = 1'b0;
        mis      = 1'b0;
        if (capture) begin
            if (dec_ok) begin
                digits_d[idx] = dec_code;
                valid_d[idx]  = 1'b1;
            end else begin
                valid_d[idx]  = 1'b0;
                new_dec       = 1'b1;
            end
            unique case (state_q)
                StSync:    if (idx == 2'd0) state_d = StExpect1;
                StExpect1: if (idx == 2'd1) state_d = StExpect2; else mis = 1'b1;
                StExpect2: if (idx == 2'd2) state_d = StExpect3; else mis = 1'b1;
                StExpect3: begin
                    if (idx == 2'd3) begin
                        state_d = StSync;
                        frame_d = 1'b1;
                    end else begin
                        mis = 1'b1;
                    end
                end
                default:   state_d = StSync;
            endcase
            if (mis) begin
                new_seq = 1'b1;
                // A stray digit 0 is treated as the start of a fresh pass.
                state_d = (idx == 2'd0) ? StExpect1 : StSync;
            end
        end
        // New errors take priority over a simultaneous clear.
        dec_err_d = (dec_err_q & ~clear_err) | new_dec;
        an_err_d  = (an_err_q  & ~clear_err) | new_an;
        seq_err_d = (seq_err_q & ~clear_err) | new_seq;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StSync;
            cnt_q     <= 4'd0;
            prev_q    <= '1;
            digits_q  <= '0;
            valid_q   <= 4'd0;
            frame_q   <= 1'b0;
            dec_err_q <= 1'b0;
            an_err_q  <= 1'b0;
            seq_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            frame_q   <= frame_d;
            dec_err_q <= dec_err_d;
            an_err_q  <= an_err_d;
            seq_err_q <= seq_err_d;
        end
    end

    assign digit0      = digits_q[0];
    assign digit1      = digits_q[1];
    assign digit2      = digits_q[2];
    assign digit3      = digits_q[3];
    assign digit_valid = valid_q;
    assign frame_done  = frame_q;
    assign decode_err  = dec_err_q;
    assign anode_err   = an_err_q;
    assign seq_err     = seq_err_q;

endmodule
